// File: rtl/key_matrix_scan_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner: FSM state encoding,
// idle column pattern and the column priority resolver.
package key_scan_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Several keys down in one row resolve to the lowest column index.
   function automatic logic [1:0] lowest_zero(input logic [3:0] p);
      logic [1:0] idx;
      idx = 2'd0;
      if (!p[0]) begin
         idx = 2'd0;
      end else if (!p[1]) begin
         idx = 2'd1;
      end else if (!p[2]) begin
         idx = 2'd2;
      end else if (!p[3]) begin
         idx = 2'd3;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Matrix-side and key-output signals of the scanner. The master side is the
// scanner itself; the slave side is the matrix plus whatever consumes the codes.
interface key_matrix_scan_if;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_vld;
   logic       key_down;

   modport master (
      input  col_n,
      output row_n,
      output key_code,
      output key_vld,
      output key_down
   );

   modport slave (
      output col_n,
      input  row_n,
      input  key_code,
      input  key_vld,
      input  key_down
   );
endinterface

// File: rtl/key_matrix_scan_col_sync.sv
// Two-flop synchroniser for the asynchronous, pulled-up column inputs.
// Resets to all-ones so an idle matrix is seen during and after reset.
module col_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d,
   output logic [3:0] q
);
   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // Metastability chain: first stage may go metastable, second stage settles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 4'b1111;
         sync_q <= 4'b1111;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: walks the rows, debounces the first key
// seen, reports it once as row*4+col, then waits for a clean release.
module key_matrix_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_CNT     = 50_000,
   parameter int DEBOUNCE_CNT = 1_000_000,
   parameter int CNT_W        = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   key_matrix_scan_if.master     kif
);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CNT - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [3:0]       col_s;
   state_e           state_q,    state_d;
   logic [1:0]       row_q,      row_d;
   logic [3:0]       row_n_q,    row_n_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [3:0]       pat_q,      pat_d;
   logic [1:0]       col_idx_q,  col_idx_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_vld_q,  key_vld_d;
   logic             key_down_q, key_down_d;

   col_sync u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (kif.col_n),
      .q     (col_s)
   );

   // Next-state logic; one counter serves the row period, debounce and release.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      pat_d      = pat_q;
      col_idx_d  = col_idx_q;
      key_code_d = key_code_q;
      key_vld_d  = 1'b0;
      key_down_d = key_down_q;
      case (state_q)
         SCAN: begin
            if (cnt_q != SCAN_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else if (col_s == ROW_IDLE) begin
               cnt_d = CNT_ZERO;
               row_d = row_q + 2'd1;
            end else begin
               cnt_d     = CNT_ZERO;
               pat_d     = col_s;
               col_idx_d = lowest_zero(col_s);
               state_d   = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (col_s != pat_q) begin
               cnt_d   = CNT_ZERO;
               state_d = SCAN;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d      = CNT_ZERO;
               key_code_d = {row_q, col_idx_q};
               key_vld_d  = 1'b1;
               key_down_d = 1'b1;
               state_d    = HELD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (col_s != ROW_IDLE) begin
               cnt_d = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d      = CNT_ZERO;
               key_down_d = 1'b0;
               row_d      = row_q + 2'd1;
               state_d    = SCAN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d      = CNT_ZERO;
            key_down_d = 1'b0;
            state_d    = SCAN;
         end
      endcase
      row_n_d = ~(4'b0001 << row_d);
   end

   // All FSM state and outputs are registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCAN;
         row_q      <= 2'd0;
         row_n_q    <= 4'b1110;
         cnt_q      <= CNT_ZERO;
         pat_q      <= ROW_IDLE;
         col_idx_q  <= 2'd0;
         key_code_q <= 4'h0;
         key_vld_q  <= 1'b0;
         key_down_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         row_n_q    <= row_n_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         col_idx_q  <= col_idx_d;
         key_code_q <= key_code_d;
         key_vld_q  <= key_vld_d;
         key_down_q <= key_down_d;
      end
   end

   assign kif.row_n    = row_n_q;
   assign kif.key_code = key_code_q;
   assign kif.key_vld  = key_vld_q;
   assign kif.key_down = key_down_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan with a behavioural 4x4 matrix and a queue of
// expected key codes checked against every key_vld pulse.
module tb_key_matrix_scan;
   localparam int SCAN_CNT     = 8;
   localparam int DEBOUNCE_CNT = 32;
   localparam int CNT_W        = 20;

   logic        clk;
   logic        rst_n;
   logic [15:0] keys;
   logic [3:0]  col_m;

   int          total;
   int          bad;
   int          vld_cnt;
   int          consumed;
   logic [3:0]  obs_code [0:15];
   logic [3:0]  exp_q [$];
   logic [3:0]  exp_code;

   key_matrix_scan_if kif ();

   key_matrix_scan #(
      .SCAN_CNT     (SCAN_CNT),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix: a pressed key shorts its column to the row being driven low.
   always_comb begin
      col_m = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!kif.row_n[r] && keys[r*4+c]) col_m[c] = 1'b0;
         end
      end
   end
   assign kif.col_n = col_m;

   // Records every key_vld pulse for the scoreboard.
   initial vld_cnt = 0;
   always @(negedge clk) begin
      if (kif.key_vld === 1'b1) begin
         obs_code[vld_cnt[3:0]] = kif.key_code;
         vld_cnt = vld_cnt + 1;
      end
   end

   task automatic wait_vld(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (vld_cnt > consumed) ok = 1'b1;
      end
   endtask

   task automatic wait_release(input int budget, output bit ok, output int cycles);
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         cycles++;
         if (kif.key_down === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      keys  = 16'h0000;
      repeat (3) @(negedge clk);
      #1;
      total++; if (kif.row_n !== 4'b1110) begin bad++; $display("FAIL reset_row_n: got %b want 1110", kif.row_n); end
      total++; if (kif.key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", kif.key_code); end
      total++; if (kif.key_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", kif.key_vld); end
      total++; if (kif.key_down !== 1'b0) begin bad++; $display("FAIL reset_down: got %b want 0", kif.key_down); end
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp_row;
      logic [3:0] one;
      int err;
      one = 4'b0001;
      err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (kif.row_n !== 4'b1110) begin bad++; $display("FAIL idle_row_start: got %b want 1110", kif.row_n); end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         exp_row = ~(one << ((k / SCAN_CNT) % 4));
         total++;
         if (kif.row_n !== exp_row) begin
            bad++;
            $display("FAIL idle_row k=%0d: got %b want %b", k, kif.row_n, exp_row);
         end
      end
      total++; if (vld_cnt !== 0) begin bad++; $display("FAIL idle_no_vld: pulses %0d want 0", vld_cnt); end
      total++; if (kif.key_code !== 4'h0) begin bad++; $display("FAIL idle_code: got %h want 0", kif.key_code); end
   endtask

   task automatic test_press_hold();
      bit ok;
      int cyc;
      @(negedge clk);
      keys[9] = 1'b1;
      exp_q.push_back(4'h9);
      wait_vld(80, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL press_vld: no pulse within budget, want code 9");
      end else begin
         exp_code = exp_q.pop_front();
         total++;
         if (obs_code[consumed] !== exp_code) begin bad++; $display("FAIL press_code: got %h want %h", obs_code[consumed], exp_code); end
         consumed++;
      end
      repeat (120) @(negedge clk);
      #1;
      total++; if (kif.key_down !== 1'b1) begin bad++; $display("FAIL press_down_held: got %b want 1", kif.key_down); end
      total++; if (vld_cnt !== consumed) begin bad++; $display("FAIL press_single: pulses %0d want %0d", vld_cnt, consumed); end
      keys[9] = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      total++; if (kif.key_down !== 1'b1) begin bad++; $display("FAIL press_down_release_early: got %b want 1", kif.key_down); end
      wait_release(60, ok, cyc);
      cyc = cyc + 10;
      total++; if (!ok) begin bad++; $display("FAIL press_release: key_down still %b", kif.key_down); end
      total++; if (cyc < 32 || cyc > 36) begin bad++; $display("FAIL press_release_time: got %0d cycles want 32..36", cyc); end
      total++; if (kif.row_n !== 4'b0111) begin bad++; $display("FAIL press_next_row: got %b want 0111", kif.row_n); end
   endtask

   task automatic test_bounce();
      bit ok;
      int cyc;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         keys[7] = ~t[0];
         repeat (4) @(negedge clk);
      end
      #1;
      total++; if (vld_cnt !== consumed) begin bad++; $display("FAIL bounce_no_vld: pulses %0d want %0d", vld_cnt, consumed); end
      keys[7] = 1'b1;
      exp_q.push_back(4'h7);
      wait_vld(100, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL bounce_vld: no pulse within budget, want code 7");
      end else begin
         exp_code = exp_q.pop_front();
         total++;
         if (obs_code[consumed] !== exp_code) begin bad++; $display("FAIL bounce_code: got %h want %h", obs_code[consumed], exp_code); end
         consumed++;
      end
      keys[7] = 1'b0;
      wait_release(60, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL bounce_release: key_down still %b", kif.key_down); end
   endtask

   task automatic test_two_keys();
      bit ok;
      int cyc;
      @(negedge clk);
      keys[2] = 1'b1;
      keys[0] = 1'b1;
      exp_q.push_back(4'h0);
      wait_vld(80, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL two_keys_vld: no pulse within budget, want code 0");
      end else begin
         exp_code = exp_q.pop_front();
         total++;
         if (obs_code[consumed] !== exp_code) begin bad++; $display("FAIL two_keys_code: got %h want %h", obs_code[consumed], exp_code); end
         consumed++;
      end
      repeat (60) @(negedge clk);
      #1;
      total++; if (vld_cnt !== consumed) begin bad++; $display("FAIL two_keys_single: pulses %0d want %0d", vld_cnt, consumed); end
      keys[2] = 1'b0;
      keys[0] = 1'b0;
      wait_release(60, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL two_keys_release: key_down still %b", kif.key_down); end
   endtask

   task automatic test_reset_abort();
      bit ok;
      bit seen;
      @(negedge clk);
      keys[15] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk); #1;
         if (kif.row_n !== 4'b0111) seen = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk); #1;
         if (kif.row_n === 4'b0111) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL abort_row3: row_n %b never reached 0111", kif.row_n); end
      // Row 3 period ends after 8 cycles, then 20 debounce cycles elapse.
      repeat (SCAN_CNT + 20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (kif.row_n !== 4'b1110) begin bad++; $display("FAIL abort_row_in_reset: got %b want 1110", kif.row_n); end
      total++; if (kif.key_down !== 1'b0) begin bad++; $display("FAIL abort_down_in_reset: got %b want 0", kif.key_down); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (kif.row_n !== 4'b1110) begin bad++; $display("FAIL abort_row_after: got %b want 1110", kif.row_n); end
      total++; if (kif.key_down !== 1'b0) begin bad++; $display("FAIL abort_down_after: got %b want 0", kif.key_down); end
      total++; if (vld_cnt !== consumed) begin bad++; $display("FAIL abort_no_vld: pulses %0d want %0d", vld_cnt, consumed); end
      exp_q.push_back(4'hF);
      wait_vld(120, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL abort_vld: no pulse within budget, want code f");
      end else begin
         exp_code = exp_q.pop_front();
         total++;
         if (obs_code[consumed] !== exp_code) begin bad++; $display("FAIL abort_code: got %h want %h", obs_code[consumed], exp_code); end
         consumed++;
      end
      total++; if (kif.key_down !== 1'b1) begin bad++; $display("FAIL abort_down_accepted: got %b want 1", kif.key_down); end
   endtask

   task automatic test_held_block();
      bit ok;
      int cyc;
      @(negedge clk);
      keys[0] = 1'b1;
      repeat (150) @(negedge clk);
      #1;
      total++; if (vld_cnt !== consumed) begin bad++; $display("FAIL held_no_vld: pulses %0d want %0d", vld_cnt, consumed); end
      total++; if (kif.key_down !== 1'b1) begin bad++; $display("FAIL held_down: got %b want 1", kif.key_down); end
      total++; if (kif.key_code !== 4'hF) begin bad++; $display("FAIL held_code_kept: got %h want f", kif.key_code); end
      keys[15] = 1'b0;
      exp_q.push_back(4'h0);
      wait_vld(150, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL held_vld: no pulse within budget, want code 0");
      end else begin
         exp_code = exp_q.pop_front();
         total++;
         if (obs_code[consumed] !== exp_code) begin bad++; $display("FAIL held_code: got %h want %h", obs_code[consumed], exp_code); end
         consumed++;
      end
      keys[0] = 1'b0;
      wait_release(60, ok, cyc);
      total++; if (!ok) begin bad++; $display("FAIL held_release: key_down still %b", kif.key_down); end
      total++; if (kif.key_code !== 4'h0) begin bad++; $display("FAIL held_code_after_release: got %h want 0", kif.key_code); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d expected codes left", exp_q.size()); end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      consumed = 0;
      test_reset();
      test_idle_scan();
      test_press_hold();
      test_bounce();
      test_two_keys();
      test_reset_abort();
      test_held_block();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
Scans a 4x4 active-low key matrix by driving rows and sampling columns, then debounces the detected key. Emits a 4-bit hex code (0-F) with a one-cycle valid strobe. It is the input-side counterpart to the multiplexed segment display driver: the display drives selects outward, this block drives rows outward and reads key state back in. Its code output feeds the display path directly.

Parameters:
SCAN_CNT, 50_000, clock cycles each row is held driven (1 ms at 50 MHz); must be >= 4
DEBOUNCE_CNT, 1_000_000, cycles a column pattern must stay stable to accept a press or release (20 ms at 50 MHz)
CNT_W, 20, width of the shared scan/debounce counter; must hold max(SCAN_CNT, DEBOUNCE_CNT)-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
col_n  input  4  matrix columns, active low, externally pulled up, asynchronous to clk
row_n  output  4  matrix row drive, active low, exactly one bit low at all times
key_code  output  4  last accepted key, row*4+col
key_vld  output  1  one-cycle pulse when a press is accepted
key_down  output  1  high while an accepted key is still held

Behaviour:
- Reset (async, rst_n low): state=SCAN, row index 0, row_n=4'b1110, counter 0, key_code=0, key_vld=0, key_down=0; col synchroniser flops reset to 4'b1111.
- col_n passes through a 2-flop synchroniser (col_s); all decisions use col_s only.
- SCAN:
  - Row index r is held for SCAN_CNT cycles.
  - col_s is sampled on the last cycle of the period (counter==SCAN_CNT-1).
  - If sample==4'b1111: r increments mod 4 (3 wraps to 0), row_n updates next cycle, counter clears.
  - Else: latch pattern P=sample, latch c = lowest index of a 0 bit in P (multiple keys in one row resolve to the lowest column), counter clears, go to DEBOUNCE. Row stays fixed.
- DEBOUNCE:
  - Counter increments while col_s==P.
  - Any cycle with col_s!=P: counter clears, return to SCAN on the same row r, no output.
  - When counter reaches DEBOUNCE_CNT-1: next cycle key_code=r*4+c, key_vld=1 for exactly one cycle, key_down=1; go to HELD, counter clears.
- HELD:
  - Row r stays driven.
  - Counter increments while col_s==4'b1111 and clears whenever any bit is 0. Presses of other keys in the same row are ignored.
  - At DEBOUNCE_CNT-1: key_down=0, r increments mod 4, go to SCAN, counter clears.
- key_code holds its value until the next accepted press; it is not cleared on release.
- Latency: a clean press at the start of row r's period produces key_vld no later than 4*SCAN_CNT + DEBOUNCE_CNT + 3 cycles after col_n falls.
- Asserting rst_n mid-debounce or mid-hold aborts without a key_vld pulse; outputs go to their reset values immediately.
- Keys in other rows pressed while one row is held are not seen until release completes.

Decomposition:
- Package key_scan_pkg: state encoding (SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2), ROW_IDLE=4'b1111, and the lowest-zero-index function for a 4-bit pattern.
- Sub-module col_sync: 4-bit two-flop synchroniser with async active-low reset to all-ones.
- Row counter, shared counter and FSM stay in key_matrix_scan.

Test Plan (SCAN_CNT=8, DEBOUNCE_CNT=32, matrix model pulls col low when the driven row matches the pressed key):
- Reset, no keys pressed -> row_n cycles 1110, 1101, 1011, 0111, 1110, each held 8 cycles; key_vld never asserts; key_code=0.
- Press key row 2 col 1 and hold 200 cycles -> exactly one key_vld pulse with key_code=4'h9; key_down=1 until 32 stable released cycles after release; row_n then advances to 0111.
- Bounce: key row 1 col 3 toggles every 5 cycles for 100 cycles, then stays pressed -> no key_vld during bouncing; one key_vld with key_code=4'h7 after stable.
- Keys row 0 col 2 and row 0 col 0 pressed together -> key_code=4'h0 (lowest column wins), single pulse.
- Press key row 3 col 3; rst_n pulsed low at debounce counter=20 -> no key_vld; row_n=1110, key_down=0 during and after reset; scanning resumes and the press is later accepted as 4'hF.
- While row 3 col 3 is held, also press row 0 col 0 -> no second pulse until release completes; then a pulse with 4'h0 appears on the next scan.
